// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : fetch FSM states (RUN, DRAIN, HALTED)
//   NOP_INST      : encoding used for an empty IF/ID slot (addi x0,x0,0)
//   RESET_PC      : default PC after reset
//   if_id_t       : contents of the IF/ID pipeline register
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture d
//   flush      : replace contents with an empty slot (wins over load)
//   d          : fetched instruction bundle
//   q          : registered bundle
// With neither load nor flush asserted the contents hold.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t empty_slot;

  always_comb begin
    empty_slot            = '0;
    empty_slot.inst       = NOP_INST;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= empty_slot;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage owning the architectural PC.
//   clk, reset         : clock, synchronous active-high reset
//   current_pc         : PC being fetched (to predictor and imem)
//   imem_dout          : instruction at current_pc (async read)
//   pred_pc/pred_taken : predictor output for current_pc
//   stall              : hold PC and IF/ID
//   halt_req           : ID holds a valid halting ecall
//   ex_mispredict      : EX redirect request, target ex_correct_pc
//   flush_id           : kill instruction in ID (= ex_mispredict)
//   if_id_*            : IF/ID register contents
//   is_halted          : program finished, sticky until reset
// Optional feature macro BP_STATS_EN adds ex_branch_resolved input and
// saturating stat_branches / stat_mispredicts counters.
module fetch_stage
#(
  parameter logic [31:0] RESET_PC     = fetch_pkg::RESET_PC,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] NOP_INST     = fetch_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] current_pc,
  input  logic [31:0] imem_dout,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        ex_mispredict,
  input  logic [31:0] ex_correct_pc,
  output logic        flush_id,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic        if_id_pred_taken,
  output logic [31:0] if_id_pred_pc,
`ifdef BP_STATS_EN
  input  logic        ex_branch_resolved,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  output logic        is_halted
);

  import fetch_pkg::*;

  localparam int unsigned CW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [CW-1:0] drain_cnt;

  logic   ifid_load;
  logic   ifid_flush;
  if_id_t ifid_d;
  if_id_t ifid_q;

  assign current_pc = pc;
  assign flush_id   = ex_mispredict;

  // IF/ID control: load only on a clean RUN cycle; empty the slot on any
  // redirect, on halt entry, and for as long as we are draining/halted.
  always_comb begin
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (state != RUN) begin
      ifid_flush = 1'b1;
    end else if (ex_mispredict) begin
      ifid_flush = 1'b1;
    end else if (halt_req && !stall) begin
      ifid_flush = 1'b1;
    end else if (!stall) begin
      ifid_load = 1'b1;
    end
  end

  always_comb begin
    ifid_d            = '0;
    ifid_d.valid      = 1'b1;
    ifid_d.inst       = imem_dout;
    ifid_d.pc         = pc;
    ifid_d.pred_taken = pred_taken;
    ifid_d.pred_pc    = pred_pc;
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign if_id_valid      = ifid_q.valid;
  assign if_id_inst       = ifid_q.inst;
  assign if_id_pc         = ifid_q.pc;
  assign if_id_pred_taken = ifid_q.pred_taken;
  assign if_id_pred_pc    = ifid_q.pred_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc        <= RESET_PC;
      drain_cnt <= '0;
      is_halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ex_mispredict) begin
            pc <= ex_correct_pc;
          end else if (halt_req && !stall) begin
            state     <= DRAIN;
            drain_cnt <= CW'(DRAIN_CYCLES - 1);
          end else if (!stall) begin
            pc <= pred_pc;
          end
        end
        DRAIN: begin
          if (ex_mispredict) begin
            state <= RUN;
            pc    <= ex_correct_pc;
          end else if (drain_cnt == '0) begin
            state     <= HALTED;
            is_halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: begin
          state <= HALTED;
        end
      endcase
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (state != HALTED) begin
      if (ex_branch_resolved && (stat_branches != '1)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (ex_mispredict && (stat_mispredicts != '1)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage that owns the architectural PC. It drives current_pc to the branch predictor and instruction memory, and advances to the predictor's pred_pc each cycle. It captures fetched instructions and prediction metadata into the IF/ID pipeline register. It handles hazard stalls, EX-stage misprediction redirects, and the ecall-halt drain sequence.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DRAIN_CYCLES, 3, cycles of bubbles inserted after halt instruction leaves ID before is_halted asserts (EX, MEM, WB)
NOP_INST, 32'h0000_0013, encoding placed in if_id_inst when slot is invalid (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
current_pc  out  32  PC being fetched; to predictor and imem address
imem_dout  in  32  instruction at current_pc (asynchronous memory read)
pred_pc  in  32  predicted next PC from branch predictor
pred_taken  in  1  predictor taken flag for current_pc
stall  in  1  hazard unit: hold PC and IF/ID
halt_req  in  1  ID stage holds a valid halting ecall
ex_mispredict  in  1  EX resolved a branch/jump whose prediction was wrong
ex_correct_pc  in  32  correct next PC for the mispredicted instruction
flush_id  out  1  kill instruction currently in ID; combinational, equals ex_mispredict
if_id_valid  out  1  IF/ID slot holds a real instruction
if_id_inst  out  32  fetched instruction
if_id_pc  out  32  PC of fetched instruction
if_id_pred_taken  out  1  prediction captured with instruction
if_id_pred_pc  out  32  predicted target captured with instruction
is_halted  out  1  program finished; sticky until reset

Behaviour:
- Reset: state=RUN, pc=RESET_PC, if_id_valid=0, if_id_inst=NOP_INST, if_id_pc=0, if_id_pred_taken=0, if_id_pred_pc=0, drain counter=0, is_halted=0. Reset takes precedence in any state, including mid-drain.
- current_pc = pc register, combinationally. There is zero-cycle latency from pc to imem/predictor. An instruction appears in IF/ID one clock after its PC is presented.
- FSM states: RUN, DRAIN, HALTED.
- RUN, per clock edge, in priority order:
  - ex_mispredict=1 → pc<=ex_correct_pc; IF/ID <= invalid (valid=0, inst=NOP_INST, pred fields 0). Stall is ignored. halt_req is ignored, because the halt is on the wrong path.
  - halt_req=1 and stall=0 → state<=DRAIN; counter<=DRAIN_CYCLES-1; pc holds; IF/ID <= invalid.
  - stall=1 → pc and all IF/ID fields hold.
  - otherwise → pc<=pred_pc; IF/ID <= {valid=1, imem_dout, pc, pred_taken, pred_pc}.
- DRAIN:
  - pc holds; IF/ID is forced invalid every cycle.
  - ex_mispredict=1 cancels the halt: state<=RUN, pc<=ex_correct_pc.
  - Otherwise, when counter==0: state<=HALTED, is_halted<=1. Else counter decrements.
  - stall and halt_req are ignored.
- HALTED: pc holds, IF/ID invalid, is_halted=1. All inputs except reset are ignored.
- Counter width is $clog2(DRAIN_CYCLES+1). DRAIN_CYCLES=1 goes DRAIN→HALTED on the first DRAIN edge.
- pc arithmetic is not performed here; next PC comes only from pred_pc or ex_correct_pc. pc wraps naturally (32-bit) if the predictor supplies 0xFFFFFFFC+4.

Optional Feature:
BP_STATS_EN.
- Defined: adds input ex_branch_resolved (1) and outputs stat_branches (32) and stat_mispredicts (32).
  - stat_branches increments on each cycle with ex_branch_resolved=1.
  - stat_mispredicts increments on each cycle with ex_mispredict=1.
  - Both saturate at 32'hFFFFFFFF, reset to 0, and freeze in HALTED.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum (RUN, DRAIN, HALTED)
  - NOP_INST constant
  - RESET_PC default
  - if_id_t packed struct {valid, inst, pc, pred_taken, pred_pc}
- One sub-module, if_id_reg: the IF/ID register with load, hold and flush controls. The FSM and PC stay in fetch_stage.

Test Plan:
- Reset, then 3 clean cycles with pred_pc=pc+4 → current_pc 0,4,8,C; if_id_pc lags by one cycle; if_id_valid=1 from cycle 2.
- pred_taken=1 and pred_pc=0x40 at pc=0x8 → next current_pc=0x40; if_id_pred_taken=1, if_id_pred_pc=0x40.
- stall=1 for 2 cycles at pc=0x10 → pc stays 0x10 and IF/ID contents unchanged; resumes with 0x14 after stall drops.
- ex_mispredict=1, ex_correct_pc=0x20, same cycle as stall=1 → flush_id=1 that cycle; next pc=0x20, if_id_valid=0.
- halt_req=1 (stall=0) → if_id_valid=0 thereafter; is_halted=1 exactly DRAIN_CYCLES(3) edges later; pc frozen; further inputs have no effect.
- halt_req, then ex_mispredict to 0x80 during DRAIN → state back to RUN, pc=0x80, is_halted stays 0; reset mid-DRAIN returns pc=RESET_PC and is_halted=0.
